// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - zero-wait AHB-Lite initiator: valid/ready commands in, pipelined NONSEQ transfers out
// One command per cycle; responses return in order two cycles after acceptance.
module ahb_lite_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic                      cmd_size,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH*8-1:0]   cmd_wdata,
   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [DATA_WIDTH*8-1:0]   rsp_rdata,
   output logic                      rsp_error,
   output logic                      hsel,
   output logic [1:0]                htrans,
   output logic [ADDR_WIDTH-1:0]     haddr,
   output logic [2:0]                hsize,
   output logic                      hwrite,
   output logic [DATA_WIDTH*8-1:0]   hwdata,
   input  logic [DATA_WIDTH*8-1:0]   hrdata,
   input  logic                      hresp
);

   localparam int DB = DATA_WIDTH * 8;
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;

   typedef enum logic {RUN, ERR_STALL} state_t;

   state_t state, state_next;
   logic   ready_en;

   logic          cmd_fire, cmd_mis, cmd_issue;
   logic [DB-1:0] cmd_lane_wdata;

   // Address-phase stage: a_valid also covers misaligned commands that never reach the bus.
   logic          a_valid, a_mis, a_write;
   logic [DB-1:0] a_wdata;

   // Data-phase stage.
   logic          d_valid, d_mis, d_write, d_size, d_lane;
   logic          d_bus, err_sample;
   logic [DB-1:0] rd_lane;

   assign cmd_fire  = cmd_valid & cmd_ready;
   assign cmd_mis   = cmd_size & cmd_addr[0];
   assign cmd_issue = cmd_fire & ~cmd_mis;

   always_comb begin
      cmd_lane_wdata = cmd_wdata;
      if (!cmd_size)
         cmd_lane_wdata = cmd_addr[0] ? {cmd_wdata[7:0], 8'h00} : {8'h00, cmd_wdata[7:0]};
   end

   assign d_bus      = d_valid & ~d_mis;
   assign err_sample = d_bus & hresp;

   always_comb begin
      rd_lane = hrdata;
      if (!d_size)
         rd_lane = d_lane ? {8'h00, hrdata[15:8]} : {8'h00, hrdata[7:0]};
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      case (state)
         RUN: begin
            cmd_ready = ready_en;
            if (err_sample)
               state_next = ERR_STALL;
         end
         ERR_STALL: state_next = RUN;
         default:   state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state     <= RUN;
         ready_en  <= 1'b0;
         a_valid   <= 1'b0;
         a_mis     <= 1'b0;
         a_write   <= 1'b0;
         a_wdata   <= '0;
         d_valid   <= 1'b0;
         d_mis     <= 1'b0;
         d_write   <= 1'b0;
         d_size    <= 1'b0;
         d_lane    <= 1'b0;
         hsel      <= 1'b0;
         htrans    <= HT_IDLE;
         haddr     <= '0;
         hsize     <= 3'b000;
         hwrite    <= 1'b0;
         hwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state    <= state_next;
         ready_en <= 1'b1;

         a_valid <= cmd_fire;
         a_mis   <= cmd_fire & cmd_mis;
         a_write <= cmd_fire & cmd_write;
         a_wdata <= cmd_lane_wdata;
         hsel    <= cmd_issue;
         htrans  <= cmd_issue ? HT_NONSEQ : HT_IDLE;
         haddr   <= cmd_issue ? cmd_addr : '0;
         hsize   <= cmd_issue ? {2'b00, cmd_size} : 3'b000;
         hwrite  <= cmd_issue & cmd_write;

         d_valid <= a_valid;
         d_mis   <= a_mis;
         d_write <= a_write;
         d_size  <= haddr_size_bit(hsize);
         d_lane  <= haddr[0];
         hwdata  <= (a_valid & ~a_mis & a_write) ? a_wdata : '0;

         // Bus inputs only count while a real data phase is active.
         rsp_valid <= d_valid;
         rsp_write <= d_write;
         rsp_error <= d_mis | err_sample;
         rsp_rdata <= (d_bus & ~d_write & ~hresp) ? rd_lane : '0;
      end
   end

   function automatic logic haddr_size_bit(input logic [2:0] sz);
      return sz[0];
   endfunction

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed bench with a transaction-queue model and a small AHB slave
module tb_ahb_lite_master;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          n_rst, cmd_valid, cmd_write, cmd_size;
   logic [AW-1:0] cmd_addr;
   logic [15:0]   cmd_wdata;
   logic          cmd_ready, rsp_valid, rsp_write, rsp_error;
   logic [15:0]   rsp_rdata;
   logic          hsel, hwrite, hresp;
   logic [1:0]    htrans;
   logic [AW-1:0] haddr;
   logic [2:0]    hsize;
   logic [15:0]   hwdata, hrdata;

   ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(2)) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .hsel(hsel), .htrans(htrans), .haddr(haddr), .hsize(hsize), .hwrite(hwrite),
      .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp)
   );

   // Slave: byte memory, halfword region 2..3 is read-only (writes there get hresp).
   logic [7:0]    smem [16];
   logic          sdp_v, sdp_w, sdp_s, idle_hresp;
   logic [AW-1:0] sdp_a;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 17) ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (!n_rst) begin
         sdp_v <= 1'b0;
         for (int i = 0; i < 16; i++) smem[i] <= init_byte(i);
      end else begin
         sdp_v <= hsel & (htrans == 2'b10);
         sdp_w <= hwrite;
         sdp_s <= hsize[0];
         sdp_a <= haddr;
         if (sdp_v && sdp_w && sdp_a[3:1] != 3'd1) begin
            if (sdp_s) begin
               smem[{sdp_a[3:1], 1'b0}] <= hwdata[7:0];
               smem[{sdp_a[3:1], 1'b1}] <= hwdata[15:8];
            end else if (sdp_a[0]) smem[sdp_a] <= hwdata[15:8];
            else                   smem[sdp_a] <= hwdata[7:0];
         end
      end
   end

   always_comb begin
      hrdata = 16'hDEAD;
      hresp  = idle_hresp;
      if (sdp_v) begin
         hresp  = sdp_w && (sdp_a[3:1] == 3'd1);
         hrdata = sdp_w ? 16'hBEEF : {smem[{sdp_a[3:1], 1'b1}], smem[{sdp_a[3:1], 1'b0}]};
      end
   end

   // Model: each accepted command lives in a queue for two edges, then becomes a response.
   typedef struct {
      int          age;
      logic        wr;
      logic        sz;
      logic [3:0]  addr;
      logic [15:0] wd;
      logic        mis;
      logic        serr;
      logic [15:0] rd;
   } txn_t;

   txn_t        q[$];
   logic [7:0]  rmem [16];
   logic        m_ready = 1'b0;
   logic        e_ready, e_hsel, e_hwrite, e_rv, e_rw, e_re;
   logic [1:0]  e_htrans;
   logic [3:0]  e_haddr;
   logic [2:0]  e_hsize;
   logic [15:0] e_hwdata, e_rd;

   int errors, checks, cyc;
   bit checking;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      txn_t t;
      logic stall;
      {e_hsel, e_hwrite, e_rv, e_rw, e_re} = '0;
      e_htrans = 2'b00; e_haddr = '0; e_hsize = '0; e_hwdata = '0; e_rd = '0;
      if (!n_rst) begin
         q.delete();
         m_ready = 1'b0;
         e_ready = 1'b0;
         for (int i = 0; i < 16; i++) rmem[i] = init_byte(i);
         return;
      end
      stall = 1'b0;
      foreach (q[i]) q[i].age++;
      if (q.size() > 0 && q[0].age == 2) begin
         t = q.pop_front();
         e_rv = 1'b1; e_rw = t.wr; e_re = t.mis | t.serr; e_rd = t.rd;
         stall = t.serr;
      end
      foreach (q[i])
         if (q[i].age == 1 && q[i].wr && !q[i].mis)
            e_hwdata = q[i].sz ? q[i].wd :
                       (q[i].addr[0] ? {q[i].wd[7:0], 8'h00} : {8'h00, q[i].wd[7:0]});
      if (m_ready && cmd_valid) begin
         t.age = 0; t.wr = cmd_write; t.sz = cmd_size; t.addr = cmd_addr; t.wd = cmd_wdata;
         t.mis  = cmd_size & cmd_addr[0];
         t.serr = !t.mis && cmd_write && cmd_addr[3:1] == 3'd1;
         t.rd   = '0;
         if (!t.wr && !t.mis)
            t.rd = t.sz ? {rmem[t.addr + 4'd1], rmem[t.addr]} : {8'h00, rmem[t.addr]};
         if (t.wr && !t.mis && !t.serr) begin
            rmem[t.addr] = t.wd[7:0];
            if (t.sz) rmem[t.addr + 4'd1] = t.wd[15:8];
         end
         if (!t.mis) begin
            e_hsel = 1'b1; e_htrans = 2'b10; e_haddr = t.addr;
            e_hwrite = t.wr; e_hsize = {2'b00, t.sz};
         end
         q.push_back(t);
      end
      m_ready = !stall;
      e_ready = m_ready;
   endtask

   task automatic compare();
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("hsel",      32'(hsel),      32'(e_hsel));
      chk("htrans",    32'(htrans),    32'(e_htrans));
      chk("haddr",     32'(haddr),     32'(e_haddr));
      chk("hwrite",    32'(hwrite),    32'(e_hwrite));
      chk("hsize",     32'(hsize),     32'(e_hsize));
      chk("hwdata",    32'(hwdata),    32'(e_hwdata));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_write", 32'(rsp_write), 32'(e_rw));
      chk("rsp_error", 32'(rsp_error), 32'(e_re));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      if (checking) compare();
   endtask

   task automatic issue(input logic wr, input logic sz, input logic [3:0] a, input logic [15:0] d);
      cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
   endtask

   task automatic idle();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 1'b0; cmd_addr = '0; cmd_wdata = '0;
   endtask

   initial begin
      int pulses;
      errors = 0; checks = 0; cyc = 0; checking = 0;

      // Reset with a pending command and a spurious hresp.
      n_rst = 1'b0; idle_hresp = 1'b1;
      issue(1'b1, 1'b1, 4'd6, 16'h1234);
      tick(); checking = 1;
      tick(); tick();
      chk("rst_hsel",   32'(hsel), 0);
      chk("rst_htrans", 32'(htrans), 0);
      chk("rst_ready",  32'(cmd_ready), 0);
      chk("rst_rsp",    32'(rsp_valid), 0);
      chk("rst_hwdata", 32'(hwdata), 0);
      n_rst = 1'b1;
      tick();
      chk("rel_ready", 32'(cmd_ready), 1);
      chk("rel_hsel",  32'(hsel), 0);
      idle();
      tick();

      // Halfword write.
      issue(1'b1, 1'b1, 4'd4, 16'd1000); tick(); idle();
      chk("t2_hsel", 32'(hsel), 1);
      chk("t2_htrans", 32'(htrans), 'h2);
      chk("t2_haddr", 32'(haddr), 4);
      chk("t2_hwrite", 32'(hwrite), 1);
      chk("t2_hsize", 32'(hsize), 1);
      tick(); chk("t2_hwdata", 32'(hwdata), 'h03E8);
      tick(); chk("t2_rsp_valid", 32'(rsp_valid), 1); chk("t2_rsp_error", 32'(rsp_error), 0);

      // Back-to-back write then read.
      issue(1'b1, 1'b1, 4'd12, 16'h8000); tick();
      issue(1'b0, 1'b1, 4'd12, 16'h0000); tick(); idle();
      chk("t3_rd_hsel", 32'(hsel), 1);
      chk("t3_rd_hwrite", 32'(hwrite), 0);
      chk("t3_hwdata", 32'(hwdata), 'h8000);
      tick(); chk("t3_rsp1_valid", 32'(rsp_valid), 1); chk("t3_rsp1_write", 32'(rsp_write), 1);
      tick(); chk("t3_rsp2_valid", 32'(rsp_valid), 1); chk("t3_rsp2_rdata", 32'(rsp_rdata), 'h8000);

      // Byte write then byte read at odd lane, then halfword readback.
      issue(1'b1, 1'b0, 4'd5, 16'h00AB); tick();
      chk("t4_hsize", 32'(hsize), 0);
      issue(1'b0, 1'b0, 4'd5, 16'h0000); tick(); idle();
      chk("t4_hwdata", 32'(hwdata), 'hAB00);
      tick(); chk("t4_wr_rdata", 32'(rsp_rdata), 0);
      tick(); chk("t4_rd_rdata", 32'(rsp_rdata), 'h00AB);
      issue(1'b0, 1'b0, 4'd4, 16'h0000); tick();
      issue(1'b0, 1'b1, 4'd4, 16'h0000); tick(); idle();
      tick(); chk("t4_lane0", 32'(rsp_rdata), 'h00E8);
      tick(); chk("t4_half", 32'(rsp_rdata), 'hABE8);

      // Misaligned halfword read.
      issue(1'b0, 1'b1, 4'd7, 16'h0000); tick(); idle();
      chk("t5_hsel", 32'(hsel), 0);
      chk("t5_htrans", 32'(htrans), 0);
      tick(); tick();
      chk("t5_rsp_valid", 32'(rsp_valid), 1);
      chk("t5_rsp_error", 32'(rsp_error), 1);
      chk("t5_rsp_rdata", 32'(rsp_rdata), 0);
      issue(1'b1, 1'b1, 4'd9, 16'h7777); tick(); idle(); tick(); tick();

      // Slave error with overlapped transfer, stall, then reset mid-stream.
      issue(1'b1, 1'b1, 4'd2, 16'h5555); tick();
      issue(1'b0, 1'b1, 4'd4, 16'h0000); tick();
      issue(1'b1, 1'b1, 4'd8, 16'h1111); tick();
      chk("t6_err", 32'(rsp_error), 1);
      chk("t6_ready", 32'(cmd_ready), 0);
      chk("t6_err_rdata", 32'(rsp_rdata), 0);
      issue(1'b1, 1'b1, 4'd10, 16'h2222); tick();
      chk("t6_idle", 32'(htrans), 0);
      chk("t6_ovl_valid", 32'(rsp_valid), 1);
      chk("t6_ovl_error", 32'(rsp_error), 0);
      chk("t6_ovl_rdata", 32'(rsp_rdata), 'hABE8);
      tick();
      chk("t6_resume_haddr", 32'(haddr), 10);
      issue(1'b1, 1'b1, 4'd14, 16'h3333); tick();
      chk("t6_hwdata", 32'(hwdata), 'h2222);
      idle(); n_rst = 1'b0; tick();
      chk("t6_rst_rsp", 32'(rsp_valid), 0);
      n_rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid) pulses++;
      end
      chk("t6_no_rsp", 32'(pulses), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Zero-wait-state AHB-Lite initiator for the FIR configuration path; the counterpart of ahb_lite_slave.
- Accepts single read/write commands on a valid/ready port and issues them as pipelined NONSEQ transfers: one address phase, then one data phase.
- Returns in-order responses carrying read data and error status.
- Used as the bus driver in the system-level FIR bench and as a host-side stub.

Parameters:
- ADDR_WIDTH, 4, address bits (haddr, cmd_addr).
- DATA_WIDTH, 2, bus width in bytes; data bits = DATA_WIDTH*8. Only 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  1  0 = byte, 1 = halfword.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  16  write data, right-justified for byte writes.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  16  read data, right-justified and zero-extended for bytes; 0 for writes.
- rsp_error  out  1  slave hresp or local misalignment.
- hsel  out  1  slave select.
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- haddr  out  ADDR_WIDTH  transfer address.
- hsize  out  3  {2'b00, size}.
- hwrite  out  1  transfer direction.
- hwdata  out  16  write data (data phase).
- hrdata  in  16  read data (data phase).
- hresp  in  1  error response (data phase).

Behaviour:
- Reset (n_rst low at a rising edge): all outputs 0; htrans = IDLE; cmd_ready = 0 during reset, 1 on the first cycle after release. Pipeline contents are discarded and no response is produced for in-flight transfers.
- Timing convention: "cycle k" is the period after rising edge k.
- Pipeline timing for a command accepted at edge k:
  - Address phase in cycle k: hsel=1, htrans=NONSEQ, haddr, hwrite and hsize all registered.
  - Data phase in cycle k+1: hwdata registered.
  - hrdata and hresp sampled at edge k+2.
  - rsp_valid=1 during cycle k+2.
- Throughput: one command per cycle. The address phase of command n+1 overlaps the data phase of command n.
- Idle cycles: when no command is accepted, the next cycle drives hsel=0, htrans=IDLE, and haddr/hwrite/hsize = 0.
- hwdata: 0 in any cycle without a write data phase.
- Byte lanes are little-endian by addr[0]:
  - Byte write at addr[0]=0: hwdata = {8'h00, wdata[7:0]}.
  - Byte write at addr[0]=1: hwdata = {wdata[7:0], 8'h00}.
  - Byte read: rsp_rdata = {8'h00, selected lane}.
  - Halfword: all 16 bits pass through.
- Misalignment (halfword with addr[0]=1):
  - The command is accepted but no bus transfer is issued; the cycle is IDLE with hsel=0.
  - The response keeps the same latency and order: rsp_error=1, rsp_rdata=0.
- Slave error (hresp=1 sampled at the end of a data phase):
  - rsp_error=1 for that response; rsp_rdata=0 for reads.
  - Any transfer already in its address phase still completes normally; there is no cancellation.
  - cmd_ready=0 for exactly one cycle (cycle k+2), and htrans=IDLE in cycle k+3.
- Sticky status: none; error reporting is per response only.
- Control: a 2-state FSM, RUN and ERR_STALL. RUN→ERR_STALL on sampled hresp; ERR_STALL→RUN unconditionally after 1 cycle.
- Data-phase hresp is ignored unless a data phase is active. The same applies to hrdata.
- Simultaneous events: a valid command arriving while ERR_STALL is active is held by the requester (ready=0) and accepted the following cycle.

Test Plan:
1. Reset with cmd_valid=1 and hresp=1 driven → every output is 0 and htrans=00 while reset is low; cmd_ready=1 on the first cycle after release.
2. Halfword write, addr 4, data 16'd1000:
   - Cycle k: hsel=1, htrans=10, haddr=4, hwrite=1, hsize=001.
   - Cycle k+1: hwdata=16'h03E8.
   - Cycle k+2: rsp_valid=1, rsp_error=0.
3. Back-to-back write then read at addr 12, data 16'h8000, against ahb_lite_slave:
   - The read's address phase overlaps the write's data phase.
   - Two consecutive rsp_valid pulses; the second has rsp_rdata=16'h8000.
4. Byte write at addr 5, data 16'h00AB → hwdata=16'hAB00 and hsize=000. A byte read of addr 5 → rsp_rdata=16'h00AB.
5. Halfword read at addr 7 → no hsel/NONSEQ cycle; rsp_valid with rsp_error=1 two cycles after acceptance.
6. Slave asserts hresp on a write to a read-only address (addr 2):
   - rsp_error=1 and cmd_ready=0 for one cycle.
   - The overlapped next transfer completes with rsp_error=0.
   - Then synchronous reset mid-stream: no further rsp_valid pulses.
